// File: rtl/rx_frame_delim_if.sv
// Signal bundle between the XGMII receive port and the RX framing stage.
// The slave side is the framing stage; the master side feeds it and consumes its outputs.
interface rx_frame_delim_if;
  logic [63:0] rxd64;
  logic [7:0]  rxc64;
  logic [63:0] rxd64_d1;
  logic [63:0] rxd64_d2;
  logic        receiving;
  logic        receiving_d1;
  logic        receiving_d2;
  logic        get_terminator;
  logic [2:0]  terminator_location;
  logic        code_err;
  logic        pream_err;
  logic        too_long;
  logic        frame_abort;

  modport master (
    output rxd64, rxc64,
    input  rxd64_d1, rxd64_d2, receiving, receiving_d1, receiving_d2,
    input  get_terminator, terminator_location, code_err, pream_err,
    input  too_long, frame_abort
  );

  modport slave (
    input  rxd64, rxc64,
    output rxd64_d1, rxd64_d2, receiving, receiving_d1, receiving_d2,
    output get_terminator, terminator_location, code_err, pream_err,
    output too_long, frame_abort
  );
endinterface

// File: rtl/rx_frame_delim.sv
// XGMII RX frame delimiter: finds Start/Terminate, realigns lane-4 starts onto
// 64-bit boundaries, checks preamble/SFD and flags coding, length and abort errors.
module rx_frame_delim #(
  parameter int TP        = 1,
  parameter int MAX_WORDS = 1520
) (
  input  logic            rxclk,
  input  logic            reset,
  rx_frame_delim_if.slave bus
);
  localparam int            CW       = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_WORDS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [7:0]    CH_START = 8'hFB;
  localparam logic [7:0]    CH_TERM  = 8'hFD;
  localparam logic [7:0]    CH_ERR   = 8'hFE;
  localparam logic [7:0]    CH_PRE   = 8'h55;
  localparam logic [7:0]    CH_SFD   = 8'hD5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_RECV = 2'd2,
    S_DROP = 2'd3
  } state_t;

  if (TP < 0 || MAX_WORDS < 1) begin : g_param_check
    $error("rx_frame_delim: TP must be >= 0 and MAX_WORDS >= 1");
  end

  // Lowest lane holding a Terminate; 8 means the word carries none.
  function automatic logic [3:0] term_lane(input logic [63:0] d, input logic [7:0] c);
    logic [3:0] lane;
    lane = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      lane = (c[i] && (d[8*i +: 8] == CH_TERM)) ? 4'(i) : lane;
    end
    return lane;
  endfunction

  function automatic logic bad_bytes(input logic [63:0] d, input logic [7:0] c,
                                     input logic [3:0] lim);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bad = bad | ((4'(i) < lim) &&
                   ((d[8*i +: 8] == CH_ERR) || (c[i] && (d[8*i +: 8] != CH_TERM))));
    end
    return bad;
  endfunction

  function automatic logic pream_ok(input logic [63:0] d, input logic [7:0] c);
    return (c == 8'h01) && (d[63:8] == {CH_SFD, {6{CH_PRE}}});
  endfunction

  logic [63:0]   rxd_r;
  logic [7:0]    rxc_r;
  logic [31:0]   rxd_p;
  logic [3:0]    rxc_p;
  logic          align_r;
  logic          err_r;
  logic [CW-1:0] cnt_r;
  state_t        state_r;

  logic [63:0]   dat_a_s;
  logic [7:0]    ctl_a_s;
  logic [3:0]    tl_s;
  logic          has_t_s;
  logic          word_bad_s;
  logic          start0_s;
  logic          start4_s;
  logic          accept_s;
  state_t        state_s;
  logic          align_s;
  logic          err_s;
  logic [CW-1:0] cnt_s;
  logic          recv_s;
  logic          get_t_s;
  logic [2:0]    loc_s;
  logic          cerr_s;
  logic          perr_s;
  logic          tlong_s;
  logic          abort_s;

  // Only the upper half of the previous word is needed for lane-4 realignment.
  assign dat_a_s    = align_r ? {rxd_r[31:0], rxd_p} : rxd_r;
  assign ctl_a_s    = align_r ? {rxc_r[3:0], rxc_p} : rxc_r;
  assign tl_s       = term_lane(dat_a_s, ctl_a_s);
  assign has_t_s    = ~tl_s[3];
  assign word_bad_s = bad_bytes(dat_a_s, ctl_a_s, tl_s);
  assign start0_s   = (rxc_r == 8'h01) && (rxd_r[7:0] == CH_START);
  assign start4_s   = (rxc_r[7:4] == 4'h1) && (rxd_r[39:32] == CH_START);

  // Input stage: register the raw XGMII word and keep the previous upper half.
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      rxd_r <= 64'h0;
      rxc_r <= 8'h00;
      rxd_p <= 32'h0;
      rxc_p <= 4'h0;
    end else begin
      rxd_r <= bus.rxd64;
      rxc_r <= bus.rxc64;
      rxd_p <= rxd_r[63:32];
      rxc_p <= rxc_r[7:4];
    end
  end

  // Frame FSM next-state and per-word strobe decode.
  always_comb begin
    state_s  = state_r;
    align_s  = align_r;
    err_s    = err_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    recv_s   = 1'b0;
    get_t_s  = 1'b0;
    loc_s    = bus.terminator_location;
    cerr_s   = 1'b0;
    perr_s   = 1'b0;
    tlong_s  = 1'b0;
    abort_s  = 1'b0;
    case (state_r)
      S_IDLE: accept_s = start0_s | start4_s;
      S_PRE: begin
        if (pream_ok(dat_a_s, ctl_a_s)) begin
          state_s = S_RECV;
          err_s   = 1'b0;
        end else begin
          perr_s  = 1'b1;
          state_s = S_DROP;
        end
      end
      S_RECV: begin
        if (has_t_s) begin
          get_t_s  = 1'b1;
          loc_s    = tl_s[2:0];
          cerr_s   = err_r | word_bad_s;
          state_s  = S_IDLE;
          accept_s = start0_s | start4_s;
        end else if (start0_s || start4_s) begin
          abort_s  = 1'b1;
          accept_s = 1'b1;
        end else if (cnt_r == MAX_CNT) begin
          tlong_s = 1'b1;
          state_s = S_DROP;
        end else begin
          recv_s = 1'b1;
          cnt_s  = cnt_r + CNT_ONE;
          err_s  = err_r | word_bad_s;
        end
      end
      S_DROP: begin
        if (has_t_s || (ctl_a_s == 8'hFF)) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DROP;
        end
      end
      default: state_s = S_IDLE;
    endcase
    // A lane-0 start is checked at once; a lane-4 start needs the next word.
    if (accept_s) begin
      cnt_s = {CW{1'b0}};
      if (start0_s) begin
        align_s = 1'b0;
        if (pream_ok(rxd_r, rxc_r)) begin
          state_s = S_RECV;
          err_s   = 1'b0;
        end else begin
          perr_s  = 1'b1;
          state_s = S_DROP;
        end
      end else begin
        align_s = 1'b1;
        state_s = S_PRE;
      end
    end else begin
      align_s = align_s;
    end
  end

  // Frame control state.
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      align_r <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      align_r <= align_s;
      err_r   <= err_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered outputs and their plain delay chain.
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      bus.rxd64_d1            <= 64'h0;
      bus.rxd64_d2            <= 64'h0;
      bus.receiving           <= 1'b0;
      bus.receiving_d1        <= 1'b0;
      bus.receiving_d2        <= 1'b0;
      bus.get_terminator      <= 1'b0;
      bus.terminator_location <= 3'd0;
      bus.code_err            <= 1'b0;
      bus.pream_err           <= 1'b0;
      bus.too_long            <= 1'b0;
      bus.frame_abort         <= 1'b0;
    end else begin
      bus.rxd64_d1            <= dat_a_s;
      bus.rxd64_d2            <= bus.rxd64_d1;
      bus.receiving           <= recv_s;
      bus.receiving_d1        <= bus.receiving;
      bus.receiving_d2        <= bus.receiving_d1;
      bus.get_terminator      <= get_t_s;
      bus.terminator_location <= loc_s;
      bus.code_err            <= cerr_s;
      bus.pream_err           <= perr_s;
      bus.too_long            <= tlong_s;
      bus.frame_abort         <= abort_s;
    end
  end
endmodule

// File: tb/tb_rx_frame_delim.sv
// Directed bench for rx_frame_delim: builds aligned frames, optionally shifts them
// to a lane-4 start, and tallies the output strobes against hand-derived values.
module tb_rx_frame_delim;
  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C = 8'hFF;
  localparam logic [63:0] SOF_D  = 64'hD5555555555555FB;
  localparam logic [7:0]  SOF_C  = 8'h01;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  rx_frame_delim_if ifa ();
  rx_frame_delim_if ifb ();

  rx_frame_delim #(.TP(1), .MAX_WORDS(1520)) dut (.rxclk(clk), .reset(reset), .bus(ifa));
  rx_frame_delim #(.TP(1), .MAX_WORDS(4)) dut_short (.rxclk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] fd [0:15];
  logic [7:0]  fc [0:15];
  int          flen;
  int          d1_stamp;

  int          n_recv, n_term, n_pream, n_abort, n_long;
  int          n_recv_b, n_term_b, n_long_b;
  int          last_loc, last_cerr, d2_err;
  logic [63:0] words [0:15];
  int          rcyc  [0:15];
  logic [1:0]  hist;
  logic [63:0] d1_prev;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      hist    = 2'b00;
      d1_prev = 64'h0;
    end else begin
      if (ifa.receiving_d1 !== hist[0] || ifa.receiving_d2 !== hist[1] ||
          ifa.rxd64_d2 !== d1_prev) d2_err++;
      hist    = {hist[0], ifa.receiving};
      d1_prev = ifa.rxd64_d1;
      if (ifa.receiving) begin
        if (n_recv < 16) begin
          words[n_recv] = ifa.rxd64_d1;
          rcyc[n_recv]  = cyc;
        end
        n_recv++;
      end
      if (ifa.get_terminator) begin
        n_term++;
        last_loc  = int'(ifa.terminator_location);
        last_cerr = int'(ifa.code_err);
      end
      if (ifa.pream_err)   n_pream++;
      if (ifa.frame_abort) n_abort++;
      if (ifa.too_long)    n_long++;
      if (ifb.receiving)      n_recv_b++;
      if (ifb.get_terminator) n_term_b++;
      if (ifb.too_long)       n_long_b++;
    end
  end

  task automatic clr_mon();
    n_recv = 0; n_term = 0; n_pream = 0; n_abort = 0; n_long = 0;
    n_recv_b = 0; n_term_b = 0; n_long_b = 0;
    last_loc = -1; last_cerr = -1;
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    ifa.rxd64 = d; ifa.rxc64 = c;
    ifb.rxd64 = d; ifb.rxc64 = c;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) drive(IDLE_D, IDLE_C);
  endtask

  function automatic logic [63:0] dword(input int i);
    return 64'h0102030405060708 + 64'h1010101010101010 * 64'(i);
  endfunction

  // Aligned frame: start word, n data words, T word with FD in lane t.
  task automatic mk_frame(input int n, input int fe_idx, input int t);
    fd[0] = SOF_D; fc[0] = SOF_C;
    for (int i = 0; i < n; i++) begin
      fd[i+1] = dword(i); fc[i+1] = 8'h00;
    end
    if (fe_idx >= 0) begin
      fd[fe_idx+1][47:40] = 8'hFE;
      fc[fe_idx+1][5]     = 1'b1;
    end
    for (int j = 0; j < 8; j++) begin
      if (j < t) begin
        fd[n+1][8*j +: 8] = 8'hA0 + 8'(j); fc[n+1][j] = 1'b0;
      end else if (j == t) begin
        fd[n+1][8*j +: 8] = 8'hFD; fc[n+1][j] = 1'b1;
      end else begin
        fd[n+1][8*j +: 8] = 8'h07; fc[n+1][j] = 1'b1;
      end
    end
    flen = n + 2;
  endtask

  task automatic send_stream(input bit lane4, input int upto);
    logic [63:0] pd;
    logic [7:0]  pc;
    pd = IDLE_D; pc = IDLE_C;
    for (int i = 0; i < upto; i++) begin
      if (!lane4) drive(fd[i], fc[i]);
      else begin
        drive({fd[i][31:0], pd[63:32]}, {fc[i][3:0], pc[7:4]});
        pd = fd[i]; pc = fc[i];
      end
      if (i == 1) d1_stamp = cyc;
    end
    if (lane4) drive({32'h07070707, pd[63:32]}, {4'hF, pc[7:4]});
  endtask

  task automatic run(input bit lane4);
    idles(2);
    @(posedge clk);
    clr_mon();
    send_stream(lane4, flen);
    idles(6);
    @(posedge clk);
  endtask

  function automatic logic any_out();
    return |{ifa.rxd64_d1, ifa.rxd64_d2, ifa.receiving, ifa.receiving_d1, ifa.receiving_d2,
             ifa.get_terminator, ifa.terminator_location, ifa.code_err, ifa.pream_err,
             ifa.too_long, ifa.frame_abort};
  endfunction

  initial begin
    ifa.rxd64 = IDLE_D; ifa.rxc64 = IDLE_C;
    ifb.rxd64 = IDLE_D; ifb.rxc64 = IDLE_C;
    d2_err = 0; hist = 2'b00; d1_prev = 64'h0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", 64'(any_out()), 64'd0);
    @(negedge clk); reset = 1'b1;
    idles(4);

    // 1: lane-0 start, 8 data words, T in lane 3
    mk_frame(8, -1, 3);
    run(1'b0);
    check_val("c1_recv_cnt", 64'(n_recv), 64'd8);
    check_val("c1_word0", words[0], dword(0));
    check_val("c1_word7", words[7], dword(7));
    check_val("c1_latency", 64'(rcyc[0] - d1_stamp), 64'd2);
    check_val("c1_term_cnt", 64'(n_term), 64'd1);
    check_val("c1_term_loc", 64'(last_loc), 64'd3);
    check_val("c1_code_err", 64'(last_cerr), 64'd0);

    // 2: same payload starting in lane 4
    run(1'b1);
    check_val("c2_recv_cnt", 64'(n_recv), 64'd8);
    check_val("c2_word0", words[0], dword(0));
    check_val("c2_word5", words[5], dword(5));
    check_val("c2_latency", 64'(rcyc[0] - d1_stamp), 64'd3);
    check_val("c2_term_cnt", 64'(n_term), 64'd1);
    check_val("c2_term_loc", 64'(last_loc), 64'd3);
    check_val("c2_code_err", 64'(last_cerr), 64'd0);

    // 3: preamble lane 3 = 54, then a good frame
    mk_frame(8, -1, 3);
    fd[0] = 64'hD5555555545555FB;
    run(1'b0);
    check_val("c3_pream_err", 64'(n_pream), 64'd1);
    check_val("c3_recv_cnt", 64'(n_recv), 64'd0);
    check_val("c3_term_cnt", 64'(n_term), 64'd0);
    fd[0] = SOF_D;
    run(1'b0);
    check_val("c3_next_recv", 64'(n_recv), 64'd8);
    check_val("c3_next_term", 64'(n_term), 64'd1);
    check_val("c3_next_pream", 64'(n_pream), 64'd0);

    // 4: FE control in lane 5 of data word 4, then a clean frame
    mk_frame(8, 3, 3);
    run(1'b0);
    check_val("c4_recv_cnt", 64'(n_recv), 64'd8);
    check_val("c4_term_cnt", 64'(n_term), 64'd1);
    check_val("c4_code_err", 64'(last_cerr), 64'd1);
    mk_frame(8, -1, 3);
    run(1'b0);
    check_val("c4_next_code_err", 64'(last_cerr), 64'd0);

    // 5: 6 data words against MAX_WORDS=4
    mk_frame(6, -1, 3);
    run(1'b0);
    check_val("c5_short_recv", 64'(n_recv_b), 64'd4);
    check_val("c5_short_too_long", 64'(n_long_b), 64'd1);
    check_val("c5_short_term", 64'(n_term_b), 64'd0);
    check_val("c5_full_recv", 64'(n_recv), 64'd6);
    check_val("c5_full_too_long", 64'(n_long), 64'd0);

    // 6: second start after 3 words, then 2 words and T in lane 0
    mk_frame(6, -1, 0);
    fd[4] = SOF_D; fc[4] = SOF_C;
    run(1'b0);
    check_val("c6_abort", 64'(n_abort), 64'd1);
    check_val("c6_recv_cnt", 64'(n_recv), 64'd5);
    check_val("c6_gap", 64'(rcyc[3] - rcyc[2]), 64'd2);
    check_val("c6_new_word0", words[3], dword(4));
    check_val("c6_term_cnt", 64'(n_term), 64'd1);
    check_val("c6_term_loc", 64'(last_loc), 64'd0);

    // 7: reset mid-frame, then a normal frame
    mk_frame(8, -1, 3);
    idles(2);
    @(posedge clk);
    clr_mon();
    send_stream(1'b0, 4);
    @(posedge clk);
    #2;
    check_val("c7_pre_reset_recv", 64'(ifa.receiving), 64'd1);
    reset = 1'b0;
    #1;
    check_val("c7_reset_outputs", 64'(any_out()), 64'd0);
    idles(3);
    @(negedge clk); reset = 1'b1;
    run(1'b0);
    check_val("c7_after_recv", 64'(n_recv), 64'd8);
    check_val("c7_after_term", 64'(n_term), 64'd1);
    check_val("c7_after_loc", 64'(last_loc), 64'd3);

    check_val("delay_chain", 64'(d2_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_frame_delim.md
Name: rx_frame_delim

Overview:
- Receive-side framing stage that sits directly upstream of the RX CRC checker and the RX data path.
- Takes raw 64-bit XGMII receive words (data plus 8 control bits) and finds the Start and Terminate characters.
- Realigns frames that start in lane 4 onto 64-bit boundaries and checks the preamble/SFD.
- Produces the delayed data and the receiving/terminator strobes consumed by CRC checking and frame assembly.

Parameters:
- TP, 1, simulation delay on non-blocking assignments.
- MAX_WORDS, 1520, maximum number of data words per frame (8-byte units) before the frame is dropped as too long.

Ports:
- rxclk  input  1  receive clock; the only clock.
- reset  input  1  asynchronous, active-low reset; named as the codebase does.
- rxd64  input  64  XGMII data; lane 0 = bits 7:0 (first byte on the wire).
- rxc64  input  8  XGMII control; bit n flags lane n as a control character.
- rxd64_d1  output  64  aligned frame data, stage 1.
- rxd64_d2  output  64  rxd64_d1 delayed by one cycle.
- receiving  output  1  aligned word on rxd64_d1 is frame payload (after SFD, before T word).
- receiving_d1  output  1  receiving delayed by one cycle.
- receiving_d2  output  1  receiving delayed by two cycles.
- get_terminator  output  1  pulse: word on rxd64_d1 contains Terminate.
- terminator_location  output  3  lane of T in that word (= number of valid bytes before T); held until the next terminator.
- code_err  output  1  pulse with get_terminator: a control/error char (0xFE or non-T control) occurred in the frame.
- pream_err  output  1  pulse: start word failed preamble/SFD check; frame dropped.
- too_long  output  1  pulse: MAX_WORDS exceeded; frame dropped.
- frame_abort  output  1  pulse: new Start seen while receiving without T; old frame dropped.

Behaviour:
- Reset (reset=0, async): every output 0, FSM in IDLE, align=0, all holding registers 0.
- Input stage: rxd64/rxc64 are registered each cycle as rxd_r/rxc_r; the previous rxd_r/rxc_r are held as rxd_p/rxc_p.
- Alignment:
  - align=0: aligned word = rxd_r.
  - align=1: aligned word = {rxd_r[31:0], rxd_p[63:32]}; control is realigned the same way.
  - align is set only when a Start is accepted.
  - Latency from rxd64 to rxd64_d1 is 2 cycles when align=0 and 3 cycles when align=1.
- Start detection on the raw registered word:
  - Lane 0: rxc_r=8'h01 and rxd_r[7:0]=FB gives align=0.
  - Lane 4: rxc_r[7:4]=4'h1 and rxd_r[39:32]=FB gives align=1.
  - Any other FB position is ignored.
- Preamble check on the aligned start word: lanes 1-6 = 8'h55, lane 7 = 8'hD5, control = 8'h01. On mismatch, pulse pream_err and go to DROP.
- FSM:
  - IDLE: on a valid Start go to RECV; receiving rises on the next aligned word.
  - RECV: receiving=1 for each aligned word with no T.
    - On an aligned word containing T (ctrl bit set and data FD in lane k, lowest k wins): receiving=0 that cycle, get_terminator=1, terminator_location=k, code_err=error flag; go to IDLE.
    - A T in lane 0 still produces get_terminator with terminator_location=0.
  - DROP: receiving=0 and no get_terminator. Return to IDLE on a T word or an all-idle word (rxc=FF).
- Error flag:
  - Set in RECV for any FE byte or any control byte other than T in the payload, including bytes before T in the T word.
  - Cleared on entering RECV.
- Length:
  - A word counter is cleared on Start and incremented per receiving word.
  - When it reaches MAX_WORDS and another non-T word arrives: pulse too_long, go to DROP.
- Abort:
  - A valid Start while in RECV pulses frame_abort; the old frame ends with receiving=0 and no get_terminator.
  - The new frame is then processed normally, with align recomputed.
- Delay chain: rxd64_d2 and receiving_d1/receiving_d2 are plain one-cycle registers from rxd64_d1/receiving, with no gating.
- Pulse rule: all pulses last exactly one cycle.

Test Plan:
1. Lane-0 start, FB 55x6 D5, then 8 data words, then a T word with FD in lane 3 -> receiving high for 8 cycles; get_terminator once, terminator_location=3, code_err=0; receiving_d2 trails receiving by 2 cycles.
2. Lane-4 start with the same payload -> rxd64_d1 words identical to case 1 (realigned), latency 3 cycles, terminator_location computed in the aligned frame.
3. Preamble byte lane 3 = 8'h54 -> pream_err pulse, receiving never asserts, no get_terminator; the next good frame is received normally.
4. FE in lane 5 of data word 4 -> frame completes, get_terminator with code_err=1; the following frame has code_err=0.
5. MAX_WORDS=4, send 6 data words then T -> receiving high for 4 words, too_long pulse on the 5th, no get_terminator.
6. Start, 3 data words, a second Start, then 2 data words and T in lane 0 -> frame_abort pulse; receiving low for one cycle between the two frames; get_terminator with terminator_location=0.
7. Assert reset mid-frame -> all outputs 0 immediately; after release, a new frame is received normally.
